// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
//
// Multiplexed hex seven-segment display driver. The scan advances one digit on
// every rising edge of the scan-enable level from the clock-enable generator.
// Display data is double-buffered: a capture made mid-frame waits in a staging
// register and is copied to the visible shadow register at the next frame wrap.
// This way a frame never shows a mix of old and new digits.
//
// Parameters
//   DIGITS      number of multiplexed digits (2..8)
//   ACTIVE_LOW  1 = an/seg/dp inverted at the output register (common anode)
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   cke_i          scan-enable level; only its rising edge is used
//   en_i           display enable; low forces the idle (blank) state
//   load_i         capture request for value_i / dp_in_i
//   value_i        hex nibbles, digit i = value_i[4i+3:4i], digit 0 rightmost
//   dp_in_i        decimal point per digit
//   blank_lz_i     leading-zero blanking enable
//   an_o           one-hot digit select
//   seg_o          segments, seg_o[0]=a .. seg_o[6]=g
//   dp_o           decimal point of the selected digit
//   frame_done_o   single-cycle pulse after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module sevenseg_scan #(
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cke_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  input  logic                  blank_lz_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_done_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // A display image is {nibbles, decimal points}; dp bits sit in the low end.
  localparam int SW = 5 * DIGITS;
  localparam logic [IW-1:0]     LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic              DP_OFF = ACTIVE_LOW;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic              cke_q;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [SW-1:0]     staged_q, staged_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              frame_done_q;

  logic              step;
  logic              wrap;
  logic [SW-1:0]     capture;

  logic [3:0]        nibble;
  logic              dpBit;
  logic              upperNonZero;
  logic              blank;
  logic [DIGITS-1:0] onehot;
  logic [6:0]        segRaw;

  // Active-high hex decode, bit order g..a.
  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Edge detect, wrap detect, double-buffer bookkeeping and next digit index.
  // A capture goes straight to the shadow only when it cannot tear a frame:
  // in IDLE, or on the wrap step itself. Disabling the display still stages
  // a capture so it is not lost, and the stage is applied at a later wrap.
  always_comb begin
    step      = cke_i & ~cke_q;
    wrap      = (state_q == SCAN) & en_i & step & (idx_q == LAST);
    capture   = {value_i, dp_in_i};
    shadow_d  = shadow_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    if (load_i) begin
      if (!en_i || ((state_q == SCAN) && !wrap)) begin
        staged_d  = capture;
        pending_d = 1'b1;
      end else begin
        shadow_d  = capture;
        pending_d = 1'b0;
      end
    end else if (wrap && pending_q) begin
      shadow_d  = staged_q;
      pending_d = 1'b0;
    end

    idx_d = idx_q;
    if (!en_i) begin
      idx_d = '0;
    end else if (step) begin
      // Compare-based wrap so non-power-of-two digit counts work.
      if ((state_q == IDLE) || (idx_q == LAST)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Pattern for the digit that becomes visible after this edge. It is built
  // from the next-state shadow so a wrap-time update shows on digit 0 of the
  // new frame immediately. A digit is blanked when it and every digit to its
  // left are zero; digit 0 always shows so a zero value still reads "0".
  always_comb begin
    nibble       = 4'h0;
    dpBit        = 1'b0;
    upperNonZero = 1'b0;
    onehot       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nibble    = shadow_d[DIGITS + 4*i +: 4];
        dpBit     = shadow_d[i];
        onehot[i] = 1'b1;
      end
      if (IW'(i) >= idx_d) begin
        upperNonZero = upperNonZero | (|shadow_d[DIGITS + 4*i +: 4]);
      end
    end
    blank  = blank_lz_i & (idx_d != '0) & ~upperNonZero;
    segRaw = blank ? 7'd0 : hexDecode(nibble);
  end

  // Scan state machine with registered display outputs. Outputs change only
  // on a step (or when the display is disabled), so they hold between steps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cke_q        <= 1'b0;
      shadow_q     <= '0;
      staged_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cke_q        <= cke_i;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staged_q     <= staged_d;
      pending_q    <= pending_d;
      frame_done_q <= wrap;
      case (state_q)
        IDLE: begin
          if (en_i && step) begin
            state_q <= SCAN;
            an_q    <= onehot ^ AN_OFF;
            seg_q   <= segRaw ^ SEG_OFF;
            dp_q    <= dpBit ^ DP_OFF;
          end else begin
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
          end
        end
        SCAN: begin
          if (!en_i) begin
            state_q <= IDLE;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
          end else if (step) begin
            an_q    <= onehot ^ AN_OFF;
            seg_q   <= segRaw ^ SEG_OFF;
            dp_q    <= dpBit ^ DP_OFF;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;

endmodule
